// File: rtl/vga_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_seq_pkg
// Description : Shared types and constants for the VGA write sequencer:
//               FSM state enum, AHB HTRANS encodings, default console
//               address and a saturating error-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FAULT = 3'd4
  } vga_state_e;

  // Only IDLE and NONSEQ transfers are ever issued
  localparam logic [1:0]  c_HTRANS_IDLE      = 2'b00;
  localparam logic [1:0]  c_HTRANS_NONSEQ    = 2'b10;

  // AHB address of the VGA console data register
  localparam logic [31:0] c_VGA_BASE_DEFAULT = 32'h5000_0000;

  // Error counter ceiling
  localparam logic [3:0]  c_ERR_MAX          = 4'hF;

  // Increment that sticks at the ceiling
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == c_ERR_MAX) ? v : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_char_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vga_char_fifo
// Description : Character queue between the requester and the AHB sequencer.
//               Power-of-two depth, wrapping pointers, head is visible without
//               popping so a failed write can be re-issued. A flush discards
//               everything held but keeps a push arriving in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_char_fifo
  import vga_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int               c_AW       = $clog2(DEPTH);
  localparam logic [c_AW-1:0]  c_PTR_ONE  = c_AW'(1);
  localparam logic [c_AW:0]    c_CNT_ONE  = (c_AW + 1)'(1);
  localparam logic [c_AW:0]    c_CNT_FULL = (c_AW + 1)'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // A full queue refuses a push even when a pop happens in the same cycle
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  assign full  = (r_count == c_CNT_FULL);
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset because count gates every read
  always_ff @(posedge HCLK) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= w_do_push ? c_CNT_ONE : '0;
      end else begin
        if (w_do_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
        case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_write_seq.sv
`default_nettype none
// ============================================================================
// Module      : vga_write_seq
// Description : Queues characters and writes each one to the duplicated VGA
//               console as a single AHB-lite NONSEQ write. After each data
//               phase a two-cycle check window watches the lockstep mismatch
//               flag; failed writes are re-issued up to MAX_RETRY times before
//               the sequencer parks in FAULT until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_write_seq
  import vga_seq_pkg::*;
#(
  parameter logic [31:0] VGA_BASE   = c_VGA_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 8,
  parameter int          MAX_RETRY  = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  input  logic [7:0]  req_data,
  output logic        req_ready,
  output logic        HSEL,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        DLS_ERROR,
  input  logic        clear_fault,
  output logic        busy,
  output logic        fault,
  output logic [3:0]  err_count
);

  localparam int                    c_RETRY_W   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [c_RETRY_W-1:0]  c_RETRY_MAX = c_RETRY_W'(MAX_RETRY);
  localparam logic [c_RETRY_W-1:0]  c_RETRY_ONE = c_RETRY_W'(1);

  vga_state_e           r_state;
  logic                 r_chk_phase;
  logic                 r_chk_err;
  logic [c_RETRY_W-1:0] r_retry;
  logic [3:0]           r_err_count;
  logic                 r_fault;
  logic                 r_hsel;
  logic                 r_hwrite;
  logic [1:0]           r_htrans;
  logic [31:0]          r_haddr;
  logic [31:0]          r_hwdata;

  logic [7:0]           w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_fail;
  logic                 w_pop;
  logic                 w_flush;

  // The mismatch flag may land in either check cycle
  assign w_fail  = r_chk_err || DLS_ERROR;
  assign w_pop   = (r_state == ST_CHECK) && r_chk_phase && !w_fail;
  assign w_flush = (r_state == ST_FAULT) && clear_fault;

  vga_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (req_valid),
    .pop     (w_pop),
    .flush   (w_flush),
    .din     (req_data),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign req_ready = !w_full;
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign fault     = r_fault;
  assign err_count = r_err_count;
  assign HSEL      = r_hsel;
  assign HWRITE    = r_hwrite;
  assign HTRANS    = r_htrans;
  assign HADDR     = r_haddr;
  assign HWDATA    = r_hwdata;

  // Sequencer FSM; bus outputs are loaded on the transition into each state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_chk_phase <= 1'b0;
      r_chk_err   <= 1'b0;
      r_retry     <= '0;
      r_err_count <= 4'd0;
      r_fault     <= 1'b0;
      r_hsel      <= 1'b0;
      r_hwrite    <= 1'b0;
      r_htrans    <= c_HTRANS_IDLE;
      r_haddr     <= 32'd0;
      r_hwdata    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state  <= ST_ADDR;
            r_hsel   <= 1'b1;
            r_hwrite <= 1'b1;
            r_htrans <= c_HTRANS_NONSEQ;
            r_haddr  <= VGA_BASE;
          end
        end
        ST_ADDR: begin
          // Address phase is held unchanged until the slave accepts it
          if (HREADY) begin
            r_state  <= ST_DATA;
            r_htrans <= c_HTRANS_IDLE;
            r_hwdata <= {24'h0, w_head};
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            r_state     <= ST_CHECK;
            r_chk_phase <= 1'b0;
            r_chk_err   <= 1'b0;
            r_hsel      <= 1'b0;
            r_hwrite    <= 1'b0;
            r_haddr     <= 32'd0;
            r_hwdata    <= 32'd0;
          end
        end
        ST_CHECK: begin
          if (!r_chk_phase) begin
            r_chk_phase <= 1'b1;
            r_chk_err   <= DLS_ERROR;
          end else if (w_fail) begin
            r_err_count <= sat_inc4(r_err_count);
            if (r_retry < c_RETRY_MAX) begin
              r_retry  <= r_retry + c_RETRY_ONE;
              r_state  <= ST_ADDR;
              r_hsel   <= 1'b1;
              r_hwrite <= 1'b1;
              r_htrans <= c_HTRANS_NONSEQ;
              r_haddr  <= VGA_BASE;
            end else begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end
          end else begin
            r_retry <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (clear_fault) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b0;
            r_retry <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_write_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_write_seq
// Description : Self-checking bench for vga_write_seq. Accepted characters
//               are queued as expected writes; a bus monitor answers the AHB
//               handshake, injects lockstep errors and pops/compares each
//               completed write against a queue-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_write_seq;

  localparam logic [31:0] VGA_BASE   = 32'h5000_0000;
  localparam int          FIFO_DEPTH = 8;
  localparam int          MAX_RETRY  = 3;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_data = 8'h00;
  logic        req_ready;
  logic        HSEL;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        DLS_ERROR = 1'b0;
  logic        clear_fault = 1'b0;
  logic        busy;
  logic        fault;
  logic [3:0]  err_count;

  vga_write_seq #(
    .VGA_BASE   (VGA_BASE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .HSEL        (HSEL),
    .HWRITE      (HWRITE),
    .HTRANS      (HTRANS),
    .HADDR       (HADDR),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .DLS_ERROR   (DLS_ERROR),
    .clear_fault (clear_fault),
    .busy        (busy),
    .fault       (fault),
    .err_count   (err_count)
  );

  always #5 HCLK = ~HCLK;

  // Reference model state
  logic [7:0] exp_q[$];
  int         attempts   = 0;
  int         exp_err    = 0;
  bit         exp_fault  = 1'b0;
  int         n_attempts = 0;
  int         n_done     = 0;

  // Monitor controls
  int err_mode   = 0;   // 0 none, 1 once, 2 always, 3 random
  int stall_left = 0;
  bit hold_all   = 1'b0;
  bit rand_ready = 1'b0;
  bit mon_en     = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic drive_ready(input bit in_data);
    if (hold_all) HREADY = 1'b0;
    else if (in_data && stall_left > 0) begin
      HREADY = 1'b0;
      stall_left--;
    end
    else if (rand_ready) HREADY = ($urandom_range(3) != 0);
    else HREADY = 1'b1;
  endtask

  // Bus monitor / responder: pops expected characters on successful writes
  initial begin : monitor
    bit e0, e1, fail_x, just;
    int pos;
    just = 1'b0;
    forever begin
      @(negedge HCLK);
      DLS_ERROR = 1'b0;
      drive_ready(1'b0);
      if (mon_en) begin
        if (just) begin
          check("err_count_after_check", 32'(err_count), exp_err);
          check("fault_after_check", 32'(fault), 32'(exp_fault));
        end
        check("hwdata_outside_data", HWDATA, 32'd0);
        if (HTRANS == 2'b10) begin
          check("haddr_nonseq", HADDR, VGA_BASE);
          check("hsel_nonseq", 32'(HSEL), 32'd1);
          check("hwrite_nonseq", 32'(HWRITE), 32'd1);
        end else begin
          check("htrans_idle", 32'(HTRANS), 32'd0);
        end
      end
      just = 1'b0;
      if (mon_en && HTRANS == 2'b10 && HREADY) begin
        do begin
          @(negedge HCLK);
          drive_ready(1'b1);
          if (mon_en) begin
            if (exp_q.size() > 0) check("hwdata_data", HWDATA, {24'h0, exp_q[0]});
            else check("hwdata_unexpected", HWDATA, 32'hDEAD_BEEF);
            check("htrans_data", 32'(HTRANS), 32'd0);
          end
        end while (!HREADY);
        n_attempts++;
        case (err_mode)
          1, 2: begin
            pos = int'($urandom_range(1));
            e0  = (pos == 0);
            e1  = (pos == 1);
            if (err_mode == 1) err_mode = 0;
          end
          3: begin
            e0 = ($urandom_range(7) == 0);
            e1 = ($urandom_range(7) == 0);
          end
          default: begin
            e0 = 1'b0;
            e1 = 1'b0;
          end
        endcase
        fail_x = e0 | e1;
        @(negedge HCLK);
        DLS_ERROR = e0;
        drive_ready(1'b0);
        if (mon_en) check("hwdata_check", HWDATA, 32'd0);
        @(negedge HCLK);
        DLS_ERROR = e1;
        drive_ready(1'b0);
        @(posedge HCLK);
        if (mon_en) begin
          if (fail_x) begin
            if (exp_err < 15) exp_err++;
            if (attempts >= MAX_RETRY) exp_fault = 1'b1;
            else attempts++;
          end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            attempts = 0;
            n_done++;
          end
          just = 1'b1;
        end
      end
    end
  end

  // Offer one character; called and returns at posedge+1
  task automatic push_char(input logic [7:0] c);
    req_valid = 1'b1;
    req_data  = c;
    check("req_ready", 32'(req_ready), 32'(exp_q.size() < FIFO_DEPTH));
    if (req_ready) exp_q.push_back(c);
    @(posedge HCLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      @(posedge HCLK); #1;
      k++;
    end
    if (k >= budget) timeout_fail("wait_idle");
    check("req_ready_idle", 32'(req_ready), 32'd1);
    check("htrans_idle_wait", 32'(HTRANS), 32'd0);
    check("err_count_idle", 32'(err_count), exp_err);
    check("fault_idle", 32'(fault), 32'(exp_fault));
  endtask

  task automatic do_clear();
    clear_fault = 1'b1;
    @(posedge HCLK); #1;
    clear_fault = 1'b0;
    exp_q.delete();
    exp_fault = 1'b0;
    attempts  = 0;
    check("fault_cleared", 32'(fault), 32'(exp_fault));
    check("busy_cleared", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_hsel", 32'(HSEL), 32'd0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
  endtask

  // Stimulus
  initial begin : stim
    int n0, na, k;
    repeat (3) @(posedge HCLK);
    #1;
    check_reset_outputs();
    @(negedge HCLK);
    HRESETn = 1'b1;
    mon_en  = 1'b1;
    @(posedge HCLK); #1;

    // Single 'A': address phase two edges after acceptance, data one later
    na = n_attempts;
    push_char(8'h41);
    check("a_still_idle", 32'(HTRANS), 32'd0);
    @(posedge HCLK); #1;
    check("a_nonseq", 32'(HTRANS), 32'h2);
    check("a_haddr", HADDR, VGA_BASE);
    @(posedge HCLK); #1;
    check("a_hwdata", HWDATA, 32'h41);
    wait_idle(50);
    check("a_attempts", n_attempts - na, 32'd1);

    // Three wait states in the data phase
    stall_left = 3;
    n0 = n_done;
    na = n_attempts;
    push_char(8'h41);
    wait_idle(50);
    check("stall_completions", n_done - n0, 32'd1);
    check("stall_attempts", n_attempts - na, 32'd1);

    // One lockstep error: re-issue, no fault
    err_mode = 1;
    na = n_attempts;
    push_char(8'h42);
    wait_idle(80);
    check("once_attempts", n_attempts - na, 32'd2);
    check("once_fault", 32'(fault), 32'd0);

    // Persistent error: exhaust retries, then fault
    err_mode = 2;
    na = n_attempts;
    push_char(8'h43);
    k = 0;
    while (!fault && k < 200) begin
      @(posedge HCLK); #1;
      k++;
    end
    if (k >= 200) timeout_fail("wait_fault");
    err_mode = 0;
    check("always_attempts", n_attempts - na, MAX_RETRY + 1);
    check("always_fault", 32'(fault), 32'(exp_fault));
    check("always_err_count", 32'(err_count), exp_err);
    n0 = n_done;
    push_char(8'h44);
    push_char(8'h45);
    repeat (3) @(posedge HCLK);
    #1;
    check("fault_hsel", 32'(HSEL), 32'd0);
    check("fault_htrans", 32'(HTRANS), 32'd0);
    check("fault_busy", 32'(busy), 32'd1);
    do_clear();
    repeat (10) @(posedge HCLK);
    #1;
    check("flushed_no_writes", n_done - n0, 32'd0);
    wait_idle(20);

    // Fill with the bus stalled: eight accepted, ninth refused
    hold_all = 1'b1;
    for (int i = 0; i < 9; i++) push_char(8'h60 + 8'(i));
    check("fill_req_ready", 32'(req_ready), 32'd0);
    clear_fault = 1'b1;
    @(posedge HCLK); #1;
    clear_fault = 1'b0;
    check("clear_ignored_ready", 32'(req_ready), 32'd0);
    check("clear_ignored_fault", 32'(fault), 32'd0);
    hold_all = 1'b0;
    n0 = n_done;
    wait_idle(300);
    check("fill_drained", n_done - n0, 32'd8);

    // Randomised traffic with random wait states and errors
    rand_ready = 1'b1;
    err_mode   = 3;
    for (int i = 0; i < 400; i++) begin
      if (fault) begin
        check("rand_fault", 32'(fault), 32'(exp_fault));
        do_clear();
      end else if ($urandom_range(1) == 1) begin
        push_char(8'($urandom));
      end else begin
        @(posedge HCLK); #1;
      end
    end
    err_mode = 0;
    if (fault) do_clear();
    wait_idle(2000);

    // Reset in the middle of a data phase
    rand_ready = 1'b0;
    stall_left = 1000000;
    push_char(8'h52);
    k = 0;
    while (HWDATA != 32'h52 && k < 20) begin
      @(posedge HCLK); #1;
      k++;
    end
    if (k >= 20) timeout_fail("wait_data_phase");
    mon_en = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge HCLK);
    HRESETn = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge HCLK); #1;
      check("post_rst_htrans", 32'(HTRANS), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound on simulation time
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/vga_write_seq.md
VGA_WRITE_SEQ -- requirements
Module: vga_write_seq

Interface
REQ-001 Parameter VGA_BASE, default 32'h5000_0000, AHB address of the VGA console data register.
REQ-002 Parameter FIFO_DEPTH, default 8, character queue depth, power of two.
REQ-003 Parameter MAX_RETRY, default 3, re-issues allowed per character after DLS error.
REQ-004 HCLK  in  1  system clock, all state on rising edge.
REQ-005 HRESETn  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 req_valid  in  1  character offered.
REQ-007 req_data  in  8  character code.
REQ-008 req_ready  out  1  queue can accept.
REQ-009 HSEL, HWRITE  out  1 each  AHB-lite master controls toward the VGA pair.
REQ-010 HTRANS  out  2  IDLE 2'b00 or NONSEQ 2'b10 only.
REQ-011 HADDR, HWDATA  out  32 each  address and write data.
REQ-012 HREADY  in  1  slave HREADYOUT.
REQ-013 DLS_ERROR  in  1  registered lockstep mismatch flag from the duplicated VGA.
REQ-014 clear_fault  in  1  single-cycle fault acknowledge.
REQ-015 busy  out  1  FSM not IDLE or queue non-empty.
REQ-016 fault  out  1  retry budget exhausted.
REQ-017 err_count  out  4  total DLS errors seen, saturating.

Function
REQ-018 Queue push SHALL occur when req_valid && req_ready; req_ready SHALL be !full; pop only on successful completion (REQ-024) or flush.
REQ-019 FSM states SHALL be IDLE, ADDR, DATA, CHECK, FAULT.
REQ-020 IDLE: queue non-empty -> ADDR next cycle; else stay; HTRANS=IDLE, HSEL=0.
REQ-021 ADDR: HSEL=1, HWRITE=1, HTRANS=NONSEQ, HADDR=VGA_BASE; -> DATA when HREADY=1, else hold all outputs stable.
REQ-022 DATA: HTRANS=IDLE, HWDATA={24'h0, queue head}; HWDATA SHALL stay stable until HREADY=1, then -> CHECK.
REQ-023 CHECK SHALL last exactly 2 cycles (covers 1-cycle DLS_ERROR register latency); DLS_ERROR=1 in either cycle marks the transfer failed.
REQ-024 CHECK without error: pop head, clear retry counter, -> IDLE.
REQ-025 CHECK with error: err_count+1 (saturate at 15); if retry counter < MAX_RETRY, increment it and -> ADDR with same head; else -> FAULT.
REQ-026 FAULT: fault=1, HTRANS=IDLE, HSEL=0, queue still accepts pushes until full; clear_fault -> flush queue, clear retry counter, fault=0, -> IDLE next cycle.
REQ-027 clear_fault outside FAULT SHALL be ignored.
REQ-028 Push to full queue SHALL be refused even if pop occurs same cycle; push and pop on non-full queue SHALL both take effect.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-030 HADDR SHALL equal VGA_BASE whenever HTRANS=NONSEQ; HWDATA 0 outside DATA.

Reset
REQ-031 HRESETn low SHALL asynchronously force: state IDLE, queue empty, retry 0, err_count 0, fault 0, busy 0, req_ready 1, HSEL 0, HWRITE 0, HTRANS 2'b00, HADDR 0, HWDATA 0.
REQ-032 Reset mid-transfer SHALL discard the in-flight character; no partial retry after release.

Structure
REQ-033 Package vga_seq_pkg SHALL hold the FSM state enum, HTRANS encodings and default VGA_BASE.
REQ-034 Queue SHALL be sub-module vga_char_fifo (push/pop/full/empty/head); FSM and AHB drive in top.

Verification
REQ-035 Push 'A' (8'h41), HREADY=1, DLS_ERROR=0 -> NONSEQ to 32'h5000_0000 one cycle after IDLE exit, HWDATA=32'h41 next cycle, queue empty, busy 0 after CHECK.
REQ-036 HREADY held 0 for 3 cycles in DATA -> HWDATA stable 32'h41 all 3 cycles, single completion.
REQ-037 DLS_ERROR pulse in CHECK once -> same character re-issued, err_count=1, no fault.
REQ-038 DLS_ERROR every CHECK -> 4 attempts total, fault=1, err_count=4; clear_fault -> queue flushed, IDLE.
REQ-039 Push 9 characters back-to-back with HREADY=0 -> 8 accepted, req_ready=0 on 9th; release drains in order.
REQ-040 Assert HRESETn=0 during DATA -> all outputs at reset values same cycle, queue empty after release.
